// File: rtl/matrix_result_reader.sv
// matrix_result_reader: walks the accelerator result buffer and streams each captured word lane by lane.
// Optional MATRD_CHECKSUM_EN appends a modulo-2^(2*BIT_LEN) checksum beat after the final data lane.
module matrix_result_reader #(
    parameter int BIT_LEN     = 8,
    parameter int OUT_PORTS   = 4,
    parameter int ADDR_LEN    = 4,
    parameter int ADDR_FIRST  = 3,
    parameter int ADDR_STRIDE = 3,
    parameter int NUM_READS   = 4,
    parameter int REST_ADDR   = 0,
    parameter int RD_LAT      = 1
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           start,
    input  logic [OUT_PORTS*2*BIT_LEN-1:0] flatsumout,
    output logic [ADDR_LEN-1:0]            AddressSelect,
    output logic                           bufferRD,
    output logic [2*BIT_LEN-1:0]           m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           m_last,
    output logic                           busy,
    output logic                           done
);
    localparam int LW = 2*BIT_LEN;
    localparam int KW = OUT_PORTS > 1 ? $clog2(OUT_PORTS) : 1;
    localparam int RW = NUM_READS > 1 ? $clog2(NUM_READS) : 1;
    localparam int TW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, SEND, DONE} state_t;

    state_t                      state_q, state_d;
    logic [KW-1:0]               lane_q, lane_d;
    logic [RW-1:0]               rd_q, rd_d;
    logic [TW-1:0]               lat_q, lat_d;
    logic [ADDR_LEN-1:0]         addr_q, addr_d;
    logic [OUT_PORTS*LW-1:0]     cap_q, cap_d;
    logic [LW-1:0]               lane_data;
    logic                        lane_end, read_end;
`ifdef MATRD_CHECKSUM_EN
    logic [LW-1:0]               csum_q, csum_d;
    logic                        csum_beat_q, csum_beat_d;
`endif

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        rd_d      = rd_q;
        lat_d     = lat_q;
        addr_d    = addr_q;
        cap_d     = cap_q;
        lane_data = cap_q[lane_q*LW +: LW];
        lane_end  = lane_q == KW'(OUT_PORTS-1);
        read_end  = rd_q == RW'(NUM_READS-1);
`ifdef MATRD_CHECKSUM_EN
        csum_d      = csum_q;
        csum_beat_d = csum_beat_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = ADDR;
                rd_d    = '0;
                addr_d  = ADDR_LEN'(ADDR_FIRST);
`ifdef MATRD_CHECKSUM_EN
                csum_d  = '0;
`endif
            end
            ADDR: begin
                state_d = WAIT;
                lat_d   = '0;
            end
            WAIT: if (lat_q == TW'(RD_LAT-1)) begin
                state_d = SEND;
                lane_d  = '0;
                cap_d   = flatsumout;
            end else begin
                lat_d = lat_q + 1'b1;
            end
            SEND: if (m_ready) begin
`ifdef MATRD_CHECKSUM_EN
                if (csum_beat_q) begin
                    csum_beat_d = 1'b0;
                    state_d     = DONE;
                end else begin
                    csum_d = csum_q + lane_data;
                    if (!lane_end) lane_d = lane_q + 1'b1;
                    else if (!read_end) begin
                        rd_d    = rd_q + 1'b1;
                        addr_d  = addr_q + ADDR_LEN'(ADDR_STRIDE);
                        state_d = ADDR;
                    end else csum_beat_d = 1'b1;
                end
`else
                if (!lane_end) lane_d = lane_q + 1'b1;
                else if (!read_end) begin
                    rd_d    = rd_q + 1'b1;
                    addr_d  = addr_q + ADDR_LEN'(ADDR_STRIDE);
                    state_d = ADDR;
                end else state_d = DONE;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            rd_q        <= '0;
            lat_q       <= '0;
            addr_q      <= ADDR_LEN'(REST_ADDR);
            cap_q       <= '0;
`ifdef MATRD_CHECKSUM_EN
            csum_q      <= '0;
            csum_beat_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            rd_q        <= rd_d;
            lat_q       <= lat_d;
            addr_q      <= addr_d;
            cap_q       <= cap_d;
`ifdef MATRD_CHECKSUM_EN
            csum_q      <= csum_d;
            csum_beat_q <= csum_beat_d;
`endif
        end
    end

    // Address is driven only while a buffer read is in flight or being streamed
    assign AddressSelect = (state_q == ADDR || state_q == WAIT || state_q == SEND) ? addr_q : ADDR_LEN'(REST_ADDR);
    assign bufferRD      = state_q == ADDR;
    assign m_valid       = state_q == SEND;
    assign busy          = state_q != IDLE;
    assign done          = state_q == DONE;
`ifdef MATRD_CHECKSUM_EN
    assign m_data = m_valid ? (csum_beat_q ? csum_q : lane_data) : '0;
    assign m_last = m_valid && csum_beat_q;
`else
    assign m_data = m_valid ? lane_data : '0;
    assign m_last = m_valid && lane_end && read_end;
`endif
endmodule

// File: doc/matrix_result_reader.md
Name: matrix_result_reader

Overview:
- Read-side companion to the matrix accelerator. Once a computation finishes, it walks the accelerator result buffer through AddressSelect/bufferRD.
- Captures each flattened flatsumout word and serialises it, lane by lane, onto a valid/ready stream toward the PS/DMA side.
- Replaces the hand-sequenced buffer reads (addresses 3,6,9,12, then rest address) with a hardware sequencer.

Parameters:
- BIT_LEN, 8, operand width; each result lane is 2*BIT_LEN bits.
- OUT_PORTS, 4, lanes per flatsumout word.
- ADDR_LEN, 4, AddressSelect width.
- ADDR_FIRST, 3, first buffer address read.
- ADDR_STRIDE, 3, address increment between reads.
- NUM_READS, 4, buffer reads per job (>=1).
- REST_ADDR, 0, idle value of AddressSelect.
- RD_LAT, 1, cycles from bufferRD assertion to valid flatsumout (>=1).

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, asynchronous, active-low
- start  in  1  begin read job; sampled only in IDLE
- flatsumout  in  OUT_PORTS*2*BIT_LEN  accelerator result word
- AddressSelect  out  ADDR_LEN  buffer address to accelerator
- bufferRD  out  1  buffer read strobe to accelerator
- m_data  out  2*BIT_LEN  stream lane data
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream accept
- m_last  out  1  final beat of job
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on job completion

Behaviour:
- Reset (Rst=0, async): state=IDLE; AddressSelect=REST_ADDR; bufferRD=0; m_data=0; m_valid=0; m_last=0; busy=0; done=0; read index=0; lane index=0.
- FSM: IDLE -> ADDR -> WAIT -> SEND -> (ADDR | DONE) -> IDLE.
- IDLE:
  - start=1 -> ADDR with read index i=0.
  - start in any other state is ignored.
- ADDR (1 cycle):
  - bufferRD=1.
  - AddressSelect = (ADDR_FIRST + i*ADDR_STRIDE) mod 2^ADDR_LEN; overflow wraps, no error.
- WAIT (RD_LAT cycles):
  - bufferRD=0; AddressSelect holds.
  - On the final WAIT edge, the capture register loads flatsumout.
  - Go to SEND with lane index k=0.
- SEND:
  - m_valid=1; m_data = captured lane k = bits [(k+1)*2*BIT_LEN-1 : k*2*BIT_LEN]; lane 0 goes first.
  - Beat transfers when m_valid && m_ready. m_data/m_last hold stable while m_ready=0.
  - After a transfer with k<OUT_PORTS-1: k++.
  - After the transfer of lane OUT_PORTS-1: if i<NUM_READS-1, then i++ and go to ADDR (m_valid=0 that cycle); otherwise go to DONE.
  - m_last=1 only on lane OUT_PORTS-1 of read NUM_READS-1.
- DONE (1 cycle): done=1; AddressSelect=REST_ADDR; m_valid=0; then IDLE.
- Minimum job length: NUM_READS*(1+RD_LAT+OUT_PORTS)+1 cycles with m_ready held high.
- Back-to-back jobs: start is not sampled in DONE; a new job needs start in IDLE (earliest 1 cycle after done).
- Reset mid-job: immediate abort to reset values; partial stream is not completed; no done pulse.
- bufferRD is never high in more than one consecutive cycle.
- flatsumout is sampled only at capture; changes outside capture have no effect.

Optional Feature:
- Macro MATRD_CHECKSUM_EN.
- Defined:
  - After the final data lane, SEND emits one extra beat: m_data = modulo-2^(2*BIT_LEN) sum of all emitted data lanes in the job.
  - m_last moves from the final data lane to the checksum beat.
  - The checksum accumulator clears on job start and on reset.
- Undefined: no accumulator, no extra beat; behaviour exactly as above.

Test Plan:
- Reset then idle: hold Rst=0, then release with start=0 for 10 cycles -> AddressSelect=0, bufferRD=0, m_valid=0, busy=0, done never pulses.
- Default job, m_ready=1, flatsumout held at {16'h0003,16'h0001,16'h0010,16'h0000} (lane3..lane0) -> bufferRD pulses with AddressSelect 3,6,9,12.
  - Required stream: 16 beats cycling 0000,0010,0001,0003.
  - m_last only on beat 16; done 1 cycle after it; total 25 cycles start-to-done.
- Backpressure: same job, m_ready toggling 1,0,0,1 -> m_data/m_last stable while m_ready=0; beat order unchanged; no lane lost or duplicated.
- Address wrap: ADDR_FIRST=14, ADDR_STRIDE=3, NUM_READS=3 -> AddressSelect sequence 14,1,4.
- Reset mid-job: assert Rst=0 during the second SEND -> outputs at reset values immediately; no done. A following start runs a full 16-beat job.
- MATRD_CHECKSUM_EN: default job data as above -> 17th beat = 16'h0050 with m_last=1; beat 16 has m_last=0.
